// File: rtl/fpga_ann50x50_pkg.sv
// Shared constants and FSM state type for the ANN50x50 neuron accumulator datapath.
package fpga_ann50x50_pkg;

  localparam int unsigned PROD_W = 40;
  localparam int unsigned N_IN   = 50;
  localparam int unsigned ACC_W  = 47;
  localparam int unsigned SHIFT  = 14;
  localparam int unsigned OUT_W  = 19;
  localparam int unsigned BIAS_W = 24;

  // Counter must hold 0..N_IN; one bit minimum keeps N_IN==1 legal.
  localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN + 1) : 1;

  localparam logic signed [ACC_W-1:0] ACT_MAX    = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(64'sd1 <<< (SHIFT - 1));

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFinish,
    StOut
  } state_e;

endpackage

// File: rtl/fpga_ann50x50_relu_sat.sv
// Combinational round-half-up, arithmetic rescale, ReLU and saturation of the neuron sum.
module fpga_ann50x50_relu_sat
  import fpga_ann50x50_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_act
);

  logic signed [ACC_W-1:0] w_rounded;
  logic signed [ACC_W-1:0] w_shifted;

  assign w_rounded = i_acc + ROUND_HALF;
  assign w_shifted = w_rounded >>> SHIFT;

  always_comb begin
    o_act = w_shifted[OUT_W-1:0];
    if (w_shifted[ACC_W-1]) begin
      o_act = '0;
    end else if (w_shifted > ACT_MAX) begin
      o_act = ACT_MAX[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fpga_ann50x50_neuron_accum.sv
// Per-neuron product accumulator: sums N_IN products plus bias, then emits one
// rounded, ReLU'd, saturated activation through a valid/ready output register.
module fpga_ann50x50_neuron_accum
  import fpga_ann50x50_pkg::*;
(
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] prod_data,
  input  logic                     prod_valid,
  input  logic                     prod_last,
  output logic                     prod_ready,
  input  logic signed [BIAS_W-1:0] bias_data,
  output logic signed [OUT_W-1:0]  act_data,
  output logic                     act_valid,
  input  logic                     act_ready,
  output logic                     err_last
);

  state_e                  r_state, w_state_d;
  logic signed [ACC_W-1:0] r_acc, w_acc_d;
  logic [CNT_W-1:0]        r_cnt, w_cnt_d;
  logic                    r_prod_ready, w_prod_ready_d;
  logic signed [OUT_W-1:0] r_act_data, w_act_data_d;
  logic                    r_act_valid, w_act_valid_d;
  logic                    r_err_last, w_err_d;

  logic                    w_accept;
  logic                    w_is_nth;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [OUT_W-1:0] w_act;

  assign w_accept   = prod_valid && r_prod_ready;
  assign w_prod_ext = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign w_bias_ext = {{(ACC_W - BIAS_W){bias_data[BIAS_W-1]}}, bias_data};

  fpga_ann50x50_relu_sat u_relu_sat (
    .i_acc (r_acc),
    .o_act (w_act)
  );

  always_comb begin
    w_state_d     = r_state;
    w_acc_d       = r_acc;
    w_cnt_d       = r_cnt;
    w_act_data_d  = r_act_data;
    w_act_valid_d = r_act_valid;
    w_err_d       = r_err_last;
    w_is_nth      = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_acc_d   = w_prod_ext + (w_bias_ext <<< SHIFT);
          w_cnt_d   = CNT_W'(1);
          w_is_nth  = (N_IN == 1);
          w_state_d = (N_IN == 1) ? StFinish : StAccum;
        end
      end
      StAccum: begin
        if (w_accept) begin
          w_acc_d  = r_acc + w_prod_ext;
          w_cnt_d  = r_cnt + CNT_W'(1);
          w_is_nth = (r_cnt == CNT_W'(N_IN - 1));
          if (w_is_nth) begin
            w_state_d = StFinish;
          end
        end
      end
      StFinish: begin
        w_act_data_d  = w_act;
        w_act_valid_d = 1'b1;
        w_state_d     = StOut;
      end
      StOut: begin
        if (act_ready) begin
          w_act_valid_d = 1'b0;
          w_cnt_d       = '0;
          w_acc_d       = '0;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Termination is count-based; a misplaced prod_last only flags the error.
    if (w_accept && (prod_last != w_is_nth)) begin
      w_err_d = 1'b1;
    end

    w_prod_ready_d = (w_state_d == StIdle) || (w_state_d == StAccum);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state      <= StIdle;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_prod_ready <= 1'b0;
      r_act_data   <= '0;
      r_act_valid  <= 1'b0;
      r_err_last   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_acc        <= w_acc_d;
      r_cnt        <= w_cnt_d;
      r_prod_ready <= w_prod_ready_d;
      r_act_data   <= w_act_data_d;
      r_act_valid  <= w_act_valid_d;
      r_err_last   <= w_err_d;
    end
  end

  assign prod_ready = r_prod_ready;
  assign act_data   = r_act_data;
  assign act_valid  = r_act_valid;
  assign err_last   = r_err_last;

endmodule

// File: tb/tb_fpga_ann50x50_neuron_accum.sv
// Directed bench for the neuron accumulator: scoreboard of model activations,
// checked with immediate assertions as each activation is presented.
module tb_fpga_ann50x50_neuron_accum;
  import fpga_ann50x50_pkg::*;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod_valid;
  logic                     prod_last;
  logic                     prod_ready;
  logic signed [BIAS_W-1:0] bias_data;
  logic signed [OUT_W-1:0]  act_data;
  logic                     act_valid;
  logic                     act_ready;
  logic                     err_last;

  longint expq[$];
  int     errors = 0;
  int     checks = 0;

  always #5 ap_clk = ~ap_clk;

  fpga_ann50x50_neuron_accum dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .bias_data  (bias_data),
    .act_data   (act_data),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .err_last   (err_last)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input longint sum, input longint bias);
    longint r;
    r = (sum + (bias <<< 14) + 64'sd8192) >>> 14;
    if (r < 0) r = 0;
    if (r > 64'sd262143) r = 64'sd262143;
    return r;
  endfunction

  function automatic longint prod_of(input int kind, input int idx);
    case (kind)
      0:       return 64'sd1 <<< 28;
      1:       return 64'sd1 <<< 14;
      2:       return -(64'sd1 <<< 20);
      3:       return (idx == 0) ? 64'sd8192 : 64'sd0;
      4:       return (idx == 0) ? 64'sd8191 : 64'sd0;
      6:       return longint'(idx + 1) <<< 14;
      default: return longint'($urandom_range(0, 33554432)) - 64'sd16777216;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_prod(input longint p, input bit last, input longint b, output bit ok);
    int t = 0;
    prod_data  = p[PROD_W-1:0];
    prod_last  = last;
    bias_data  = b[BIAS_W-1:0];
    prod_valid = 1'b1;
    while (!prod_ready && t < 100) begin
      @(negedge ap_clk);
      t++;
    end
    ok = prod_ready;
    if (ok) begin
      @(negedge ap_clk);
    end else begin
      check("prod_ready_wait", prod_ready, 1);
    end
  endtask

  task automatic send_neuron(input int kind, input longint bias, input int last_at,
                             input int stop_at);
    longint sum = 0;
    longint p;
    bit     ok;
    for (int i = 0; i < stop_at; i++) begin
      p = prod_of(kind, i);
      sum += p;
      push_prod(p, (i + 1) == last_at, bias, ok);
      if (!ok) break;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    if (stop_at == N_IN) expq.push_back(model(sum, bias));
  endtask

  task automatic collect(input string tag);
    int     t = 0;
    longint e = -1;
    while (!act_valid && t < 10) begin
      @(negedge ap_clk);
      t++;
    end
    check({tag, "_valid"}, act_valid, 1);
    if (expq.size() > 0) e = expq.pop_front();
    check({tag, "_data"}, act_data, e);
    if (act_ready) @(negedge ap_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e;
    int     t;
    ap_rst_n   = 1'b0;
    prod_data  = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    bias_data  = '0;
    act_ready  = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("rst_prod_ready", prod_ready, 0);
    check("rst_act_valid", act_valid, 0);
    check("rst_act_data", act_data, 0);
    check("rst_err_last", err_last, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Saturation: 50 x 1.0 -> clipped to the activation maximum.
    send_neuron(0, 0, 50, 50);
    collect("sat");
    check("sat_err_last", err_last, 0);

    // Bias and latency: result visible exactly two edges after the Nth product is driven.
    send_neuron(1, 64'sd3 <<< 14, 50, 50);
    check("lat_edge1_valid", act_valid, 0);
    @(negedge ap_clk);
    check("lat_edge2_valid", act_valid, 1);
    check("bias_const", act_data, 49202);
    e = expq.pop_front();
    check("bias_model", act_data, e);
    @(negedge ap_clk);

    send_neuron(2, 0, 50, 50);
    collect("relu");
    check("relu_err_last", err_last, 0);

    send_neuron(3, 0, 50, 50);
    collect("round_up");
    send_neuron(4, 0, 50, 50);
    collect("round_dn");

    send_neuron(5, longint'($urandom_range(0, 131072)) - 64'sd65536, 50, 50);
    collect("rand_a");

    // Backpressure with the next neuron's first product held on the input.
    act_ready = 1'b0;
    send_neuron(5, longint'($urandom_range(0, 131072)) - 64'sd65536, 50, 50);
    prod_data  = PROD_W'(64'sd1 <<< 14);
    prod_last  = 1'b0;
    bias_data  = BIAS_W'(64'sd2 <<< 14);
    prod_valid = 1'b1;
    t = 0;
    while (!act_valid && t < 10) begin
      @(negedge ap_clk);
      t++;
    end
    e = (expq.size() > 0) ? expq.pop_front() : -1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", act_valid, 1);
      check("bp_data", act_data, e);
      check("bp_prod_ready", prod_ready, 0);
      @(negedge ap_clk);
    end
    act_ready = 1'b1;
    @(negedge ap_clk);
    check("bp_release_valid", act_valid, 0);
    check("bp_release_ready", prod_ready, 1);
    send_neuron(6, 64'sd2 <<< 14, 50, 50);
    collect("bp_next");

    // prod_last on the 30th product flags a sticky error; count still governs.
    send_neuron(1, 0, 30, 50);
    collect("errn");
    check("err_set", err_last, 1);
    send_neuron(5, 0, 50, 50);
    collect("err_sticky_n");
    check("err_sticky", err_last, 1);

    // Reset while the 25th product is offered.
    send_neuron(1, 64'sd7 <<< 14, 50, 24);
    prod_data  = PROD_W'(64'sd1 <<< 14);
    prod_valid = 1'b1;
    ap_rst_n   = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_err", err_last, 0);
    check("mid_rst_ready", prod_ready, 0);
    check("mid_rst_valid", act_valid, 0);
    check("mid_rst_data", act_data, 0);
    prod_valid = 1'b0;
    ap_rst_n   = 1'b1;
    @(negedge ap_clk);
    send_neuron(6, 64'sd2 <<< 14, 50, 50);
    collect("fresh");
    check("fresh_err", err_last, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
